// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding and RISC-V load/store funct3 codes for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: byte enables, store replication, load shift/extension and access legality checks.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_fmt,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        be         = funct3 == F3_B ? 4'b0001 << offset :
                     funct3 == F3_H ? 4'b0011 << offset : 4'b1111;
        wdata_rep  = funct3 == F3_B ? {4{rs2[7:0]}} :
                     funct3 == F3_H ? {2{rs2[15:0]}} : rs2;
        rdata_fmt  = funct3 == F3_B  ? {{24{shifted[7]}}, shifted[7:0]} :
                     funct3 == F3_BU ? {24'd0, shifted[7:0]} :
                     funct3 == F3_H  ? {{16{shifted[15]}}, shifted[15:0]} :
                     funct3 == F3_HU ? {16'd0, shifted[15:0]} :
                     funct3 == F3_W  ? shifted : 32'd0;
        misaligned = (funct3[1:0] == 2'b01 && offset[0]) || (funct3[1:0] == 2'b10 && offset != 2'b00);
        illegal    = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: core-to-memory load/store bridge with request/grant/response handshake and timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_t        state_q, state_d;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              idle, bad;
    logic [3:0]        be;
    logic [31:0]       wdata_rep, rdata_fmt;
    logic              misaligned, illegal;

    assign idle = state_q == IDLE;

    // In IDLE the aligner checks the incoming request; afterwards it works on the latched access.
    lsu_data_align u_align (
        .funct3     (idle ? req_funct3 : funct3_q),
        .offset     (idle ? req_addr[1:0] : addr_q[1:0]),
        .rs2        (wdata_q),
        .rdata      (mem_rdata),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .rdata_fmt  (rdata_fmt),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign bad = illegal || misaligned || (req_write && req_funct3[2]);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            if (idle && req_valid) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_valid) state_d = bad ? ERR : REQ;
            REQ:  if (mem_gnt) state_d = WAIT;
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                    rdata_d = write_q ? 32'd0 : rdata_fmt;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ERR;
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (state_q == WAIT && state_d == WAIT) ? cnt_q + 8'd1 : 8'd0;
    end

    always_comb begin
        req_ready  = idle;
        mem_req    = state_q == REQ;
        mem_we     = mem_req && write_q;
        mem_be     = mem_req ? (write_q ? be : 4'b1111) : 4'b0000;
        mem_addr   = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata  = mem_we ? wdata_rep : 32'd0;
        resp_valid = state_q == RESP || state_q == ERR;
        resp_error = state_q == ERR;
        resp_rdata = state_q == RESP ? rdata_q : 32'd0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard-driven bench for load_store_unit with a simple memory responder.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_gnt = 1'b0, mem_we, mem_rvalid = 1'b0;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;

    typedef struct packed {logic err; logic [31:0] data; logic [7:0] lat;} exp_t;
    exp_t sb[$];
    exp_t e;
    int checks = 0, errors = 0;
    logic got_v, got_e, saw_req;
    logic [31:0] got_d;
    int lat;

    logic [2:0]  lf3  [6] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_B};
    logic [31:0] la   [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h104, 32'h101};
    logic [31:0] lrd  [6] = '{32'h80112233, 32'h80112233, 32'h80017FFF, 32'h80017FFF, 32'hDEADBEEF, 32'h00007F00};
    logic [31:0] lexp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'hDEADBEEF, 32'h0000007F};
    logic        ew   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  ef3  [4] = '{F3_W, 3'b011, 3'b100, F3_H};
    logic [31:0] ea   [4] = '{32'h101, 32'h100, 32'h100, 32'h103};

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Presents one access for a single cycle, then scrambles the core inputs.
    task automatic accept(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_write = ~w; req_funct3 = 3'b111; req_addr = $urandom; req_wdata = $urandom;
    endtask

    // Memory responder: grant gd cycles late, rvalid rd cycles after WAIT entry; records the response.
    task automatic serve(input int gd, input int rd, input logic [31:0] rdat, input bit respond);
        got_v = 1'b0; got_e = 1'b0; got_d = '0; lat = -1; saw_req = 1'b0;
        for (int c = 1; c < TO + 40 && !got_v; c++) begin
            if (mem_req) saw_req = 1'b1;
            if (resp_valid) begin got_v = 1'b1; got_e = resp_error; got_d = resp_rdata; lat = c; end
            mem_gnt    = c == 1 + gd;
            mem_rvalid = respond && c == 2 + gd + rd;
            mem_rdata  = mem_rvalid ? rdat : 32'h5A5AA5A5;
            @(negedge clk);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, mem_req, resp_valid, resp_error, mem_we} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 10000", {req_ready, mem_req, resp_valid, resp_error, mem_we});
        end
        checks++;
        if ({mem_be, mem_addr, mem_wdata, resp_rdata} !== '0) begin
            errors++; $display("FAIL reset_data: be %h addr %h wdata %h rdata %h exp all 0", mem_be, mem_addr, mem_wdata, resp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loads;
        for (int i = 0; i < 6; i++) begin
            sb.push_back({1'b0, lexp[i], 8'd3});
            accept(1'b0, lf3[i], la[i], 32'hFFFFFFFF);
            checks++;
            if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, la[i] & 32'hFFFFFFFC}) begin
                errors++; $display("FAIL load%0d_req: req %b we %b be %h addr %h exp 1 0 f %h", i, mem_req, mem_we, mem_be, mem_addr, la[i] & 32'hFFFFFFFC);
            end
            serve(0, 0, lrd[i], 1'b1);
            e = sb.pop_front();
            checks += 3;
            if (lat !== int'(e.lat)) begin errors++; $display("FAIL load%0d_lat: got %0d exp %0d", i, lat, e.lat); end
            if (got_e !== e.err) begin errors++; $display("FAIL load%0d_err: got %b exp %b", i, got_e, e.err); end
            if (got_d !== e.data) begin errors++; $display("FAIL load%0d_data: got %h exp %h", i, got_d, e.data); end
        end
    endtask

    task automatic test_store_half;
        sb.push_back({1'b0, 32'd0, 8'd3});
        accept(1'b1, F3_H, 32'h202, 32'h1234ABCD);
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1100, 32'h200, 32'hABCDABCD}) begin
            errors++; $display("FAIL sh_req: req %b we %b be %b addr %h wdata %h exp 1 1 1100 200 abcdabcd", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        serve(0, 0, 32'hFFFFFFFF, 1'b1);
        e = sb.pop_front();
        checks += 3;
        if (lat !== int'(e.lat)) begin errors++; $display("FAIL sh_lat: got %0d exp %0d", lat, e.lat); end
        if (got_e !== e.err) begin errors++; $display("FAIL sh_err: got %b exp %b", got_e, e.err); end
        if (got_d !== e.data) begin errors++; $display("FAIL sh_data: got %h exp %h", got_d, e.data); end
    endtask

    task automatic test_errors;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({1'b1, 32'd0, 8'd1});
            accept(ew[i], ef3[i], ea[i], 32'h11223344);
            serve(0, 0, 32'h0, 1'b0);
            e = sb.pop_front();
            checks += 4;
            if (lat !== int'(e.lat)) begin errors++; $display("FAIL err%0d_lat: got %0d exp %0d", i, lat, e.lat); end
            if (got_e !== e.err) begin errors++; $display("FAIL err%0d_err: got %b exp %b", i, got_e, e.err); end
            if (got_d !== e.data) begin errors++; $display("FAIL err%0d_data: got %h exp %h", i, got_d, e.data); end
            if (saw_req !== 1'b0) begin errors++; $display("FAIL err%0d_memreq: got %b exp 0", i, saw_req); end
        end
    endtask

    task automatic test_gnt_delay;
        sb.push_back({1'b0, 32'd0, 8'd6});
        accept(1'b1, F3_W, 32'h304, 32'hCAFEF00D);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, req_ready} !== {1'b1, 1'b1, 4'hF, 32'h304, 32'hCAFEF00D, 1'b0}) begin
                errors++; $display("FAIL gnt_hold c%0d: req %b we %b be %h addr %h wdata %h rdy %b", c, mem_req, mem_we, mem_be, mem_addr, mem_wdata, req_ready);
            end
            mem_gnt = c == 4;
            mem_rvalid = c == 2;
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL gnt_drop: mem_req %b exp 0", mem_req); end
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        e = sb.pop_front();
        checks += 2;
        if ({resp_valid, resp_error} !== {1'b1, e.err}) begin errors++; $display("FAIL gnt_resp: valid/err %b%b exp 1%b", resp_valid, resp_error, e.err); end
        if (resp_rdata !== e.data) begin errors++; $display("FAIL gnt_data: got %h exp %h", resp_rdata, e.data); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        sb.push_back({1'b1, 32'd0, 8'(2 + TO)});
        accept(1'b0, F3_W, 32'h400, 32'h0);
        serve(0, 0, 32'h0, 1'b0);
        e = sb.pop_front();
        checks += 2;
        if (lat !== int'(e.lat)) begin errors++; $display("FAIL to_lat: got %0d exp %0d", lat, e.lat); end
        if ({got_e, got_d} !== {e.err, e.data}) begin errors++; $display("FAIL to_resp: err %b data %h exp %b %h", got_e, got_d, e.err, e.data); end
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL to_stray: valid %b ready %b exp 0 1", resp_valid, req_ready); end
        sb.push_back({1'b0, 32'h13572468, 8'd3});
        accept(1'b0, F3_W, 32'h408, 32'h0);
        serve(0, 0, 32'h13572468, 1'b1);
        e = sb.pop_front();
        checks += 2;
        if (lat !== int'(e.lat)) begin errors++; $display("FAIL to_next_lat: got %0d exp %0d", lat, e.lat); end
        if ({got_e, got_d} !== {e.err, e.data}) begin errors++; $display("FAIL to_next: err %b data %h exp %b %h", got_e, got_d, e.err, e.data); end
    endtask

    task automatic test_reset_mid;
        accept(1'b0, F3_W, 32'h500, 32'h0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({req_ready, mem_req, resp_valid} !== 3'b100) begin errors++; $display("FAIL rstmid: ready/req/valid %b exp 100", {req_ready, mem_req, resp_valid}); end
        mem_rvalid = 1'b1; mem_rdata = 32'h76543210;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL rstmid_late: ready/valid %b exp 10", {req_ready, resp_valid}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_loads();
        test_store_half();
        test_errors();
        test_gnt_delay();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage (ALU result = address, register-bank rs2 = store data) and a word-addressed data memory with a request/grant/response handshake.
- Formats byte, halfword and word loads and stores: byte enables, store-data replication, load shifting and sign/zero extension.
- Detects misaligned accesses and illegal funct3 values.
- Stalls the core through a valid/ready handshake and times out hung memory accesses.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT, 16, maximum cycles spent in WAIT before an error response is forced (range 2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept an access this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store instruction.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  32  formatted load data; 0 for stores and errors.
- resp_error  out  1  qualifies resp_valid: misaligned, illegal funct3 or timeout.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word-aligned address: {req_addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  replicated store data.
- mem_rvalid  in  1  memory response, for reads and writes.
- mem_rdata  in  32  raw read word.

Behaviour:
- States: IDLE, REQ, WAIT, RESP, ERR.
- Reset values: state = IDLE; req_ready = 1; all other outputs = 0; timeout counter = 0.
- IDLE:
  - req_ready = 1. Acceptance occurs on req_valid && req_ready; the unit then latches write, funct3, addr and wdata.
  - Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: funct3 000 SB, 001 SH, 010 SW.
  - Misaligned: halfword with addr[0] = 1; word with addr[1:0] != 0.
  - Illegal or misaligned access -> ERR, with no memory access. Otherwise -> REQ.
- REQ:
  - req_ready = 0. mem_req = 1; we/be/addr/wdata are held stable until mem_gnt.
  - On mem_gnt -> WAIT, mem_req = 0 next cycle.
  - mem_rvalid is ignored in REQ.
- WAIT:
  - The counter increments each cycle.
  - On mem_rvalid -> RESP, capturing mem_rdata.
  - If the counter reaches TIMEOUT-1 with no rvalid -> ERR.
  - The counter clears on leaving WAIT.
- RESP: resp_valid = 1 and resp_error = 0 for exactly one cycle, then -> IDLE.
- ERR: resp_valid = 1, resp_error = 1, resp_rdata = 0 for exactly one cycle, then -> IDLE.
- req_ready is 1 only in IDLE, so a new access is accepted at the earliest on the cycle after the resp_valid pulse.
- Latency: the acceptance edge is cycle 0.
  - mem_req is high in cycle 1.
  - If gnt arrives in cycle 1, rvalid can arrive in cycle 2 at the earliest.
  - resp_valid is high in cycle 3.
  - Errors: resp_valid is high in cycle 1.
- Store formatting, with o = addr[1:0]:
  - SB: be = 4'b0001 << o; wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << o; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111; wdata = rs2.
  - Loads: mem_we = 0, be = 4'b1111.
- Load formatting: s = mem_rdata >> (8*o), then:
  - LB: sign-extend s[7:0].
  - LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0].
  - LHU: zero-extend s[15:0].
  - LW: s.
  - resp_rdata is registered; a stored response must be 0.
- A stray mem_rvalid in IDLE, REQ, RESP or ERR is ignored, including one arriving late after a reset or timeout.
- Reset mid-operation: at the reset edge the state returns to IDLE, mem_req drops and any pending response is discarded.
- Core-side inputs are sampled only at acceptance; changes while busy have no effect.

Decomposition:
- Package lsu_pkg:
  - state enum lsu_state_t {IDLE, REQ, WAIT, RESP, ERR}.
  - funct3 localparams F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101.
- One combinational sub-module, lsu_data_align:
  - Inputs: funct3, offset, rs2, rdata.
  - Outputs: be, wdata_rep, rdata_fmt, misaligned, illegal.
  - The FSM, the timeout counter and the registers stay in load_store_unit.

Test Plan:
- LB at addr 0x103, rdata 0x80_11_22_33, gnt in cycle 1, rvalid in cycle 2 -> resp_valid in cycle 3, rdata 0xFFFFFF80, error 0.
- LBU at the same address and data -> resp_rdata 0x00000080.
- SH at addr 0x202, rs2 0x1234ABCD -> mem_addr 0x200, be 4'b1100, wdata 0xABCDABCD, we 1; after rvalid, resp_valid with rdata 0.
- LW at addr 0x101 -> resp_valid + resp_error in cycle 1, mem_req never asserted.
- Load funct3 3'b011 -> error response in cycle 1.
- SW with gnt delayed 3 cycles -> mem_req and all mem_* signals stable until gnt; req_ready 0 throughout.
- LW with gnt but no rvalid -> error response after TIMEOUT cycles in WAIT.
- A later rvalid in IDLE is ignored, and the next access completes normally.
- rst asserted in WAIT -> next cycle IDLE, req_ready 1, mem_req 0, no resp_valid.
